fft_bitrev_reorder: RTL

Output reorder stage that sits directly downstream of the 8-point radix-2 SDF FFT pipeline (fft_8 → fft_4 → fft_2). The pipeline emits each frame's bins in bit-reversed order. This block buffers one frame in a ping-pong memory and re-emits it in natural order (X[0] … X[N-1]) with frame markers. Buffering runs at one sample per clock with no backpressure.

---
 rtl/fft_bitrev_reorder.sv | 113 +++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong bit-reversed to natural-order FFT output reorder
// Optional sticky resync flag port resync_err under FFT_REORDER_ERR_EN.
module fft_bitrev_reorder #(
   parameter int WIDTH = 12,
   parameter int LOG2N = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_first,
   input  logic signed [WIDTH-1:0] in_r,
   input  logic signed [WIDTH-1:0] in_i,
   output logic                    out_valid,
   output logic                    out_first,
   output logic                    out_last,
`ifdef FFT_REORDER_ERR_EN
   output logic                    resync_err,
`endif
   output logic signed [WIDTH-1:0] out_r,
   output logic signed [WIDTH-1:0] out_i
);

   localparam int N = 1 << LOG2N;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] v;
      for (int b = 0; b < LOG2N; b++) v[b] = a[LOG2N-1-b];
      return v;
   endfunction

   logic [2*WIDTH-1:0] r_mem [0:2*N-1];
   logic               r_wbank;
   logic [LOG2N-1:0]   r_wcnt;
   logic [LOG2N-1:0]   r_rcnt;
   logic               r_rd_active;
   logic [2*WIDTH-1:0] r_rdata;
   logic [LOG2N-1:0]   r_ridx;
   logic               r_rvalid;

   logic [LOG2N-1:0]   w_wr_idx;
   logic               w_complete;
   logic               w_resync;

   // in_first pins the sample to bin 0 and restarts the frame count
   assign w_wr_idx   = in_first ? '0 : bitrev(r_wcnt);
   assign w_complete = in_valid && !in_first && (r_wcnt == '1);
   assign w_resync   = in_valid && in_first && (r_wcnt != '0);

   // Banks never collide: reads always use the bank opposite the writer
   always_ff @(posedge clk) begin
      if (in_valid)
         r_mem[{r_wbank, w_wr_idx}] <= {in_r, in_i};
      if (r_rd_active)
         r_rdata <= r_mem[{~r_wbank, r_rcnt}];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbank     <= 1'b0;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_rd_active <= 1'b0;
         r_ridx      <= '0;
         r_rvalid    <= 1'b0;
      end else begin
         if (in_valid)
            r_wcnt <= in_first ? LOG2N'(1) : r_wcnt + LOG2N'(1);
         if (w_complete)
            r_wbank <= ~r_wbank;

         r_rvalid <= r_rd_active;
         r_ridx   <= r_rcnt;

         if (w_complete) begin
            r_rd_active <= 1'b1;
            r_rcnt      <= '0;
         end else if (r_rd_active) begin
            r_rcnt <= r_rcnt + LOG2N'(1);
            if (r_rcnt == '1)
               r_rd_active <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
      end else begin
         out_valid <= r_rvalid;
         out_first <= r_rvalid && (r_ridx == '0);
         out_last  <= r_rvalid && (r_ridx == '1);
         out_r     <= r_rdata[2*WIDTH-1:WIDTH];
         out_i     <= r_rdata[WIDTH-1:0];
      end
   end

`ifdef FFT_REORDER_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)
         resync_err <= 1'b0;
      else if (w_resync)
         resync_err <= 1'b1;
   end
`else
   logic w_unused;
   assign w_unused = w_resync;
`endif

endmodule
